vga_ctrl: RTL and testbench
===========================

# vga_ctrl

Display-side timing generator for the image path: produces 640x480 @ 60 Hz VGA timing from the 100 MHz system clock, issues the `pixel_x`/`pixel_y` read address to `imemory`, and takes back the 12-bit `rgb` word. It drives the board's VGA connector with sync and colour outputs that are aligned to each other. It sits between `imemory` (upstream) and the VGA pins (downstream).

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels (line = 800).
- `V_VIS`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines (frame = 525).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable. Low holds the timing at the origin.
- `pixel_x` out 10: column address to `imemory`.
- `pixel_y` out 10: row address to `imemory`.
- `rgb_in` in 12: pixel from `imemory`, {R[11:8],G[7:4],B[3:0]}.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour to the DAC.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `video_on` out 1: output stage is in the visible region.
- `frame_start` out 1: one-clk pulse at each frame origin.

## Operation
- Divider `div` counts 0..CLK_DIV-1 while `en`=1. `tick` = (`div`==CLK_DIV-1).
- Counters `h` (0..799) and `v` (0..524) advance on `tick`. `h` wraps to 0 and increments `v`. `v` wraps to 0 after 524.
- Region definitions:
  - visible = `h`<640 and `v`<480.
  - hsync region = `h` in [656,751].
  - vsync region = `v` in [490,491].
- Address output:
  - `pixel_x`=`h` and `pixel_y`=`v` when visible, else 0.
  - Both are driven directly from counter registers, with no added combinational logic after the flops beyond the visible mux.
  - Both are held stable for the whole pixel period.
- Output stage (registered on `tick`, using counter values before the increment):
  - `video_on` <= visible.
  - {`vga_r`,`vga_g`,`vga_b`} <= visible ? `rgb_in` : 0.
  - `hsync` <= ~hsync region.
  - `vsync` <= ~vsync region.
- `frame_start` = 1 for exactly the clk in which the counters move from (799,524) to (0,0). It is also 1 in the first clk after `en` rises from reset or from a stopped state.
- `en` low:
  - `div`, `h` and `v` are forced to 0.
  - Outputs go to reset values on the next clk.
  - Rising `en` restarts a full frame from (0,0).
- Reset (`rst`=0, at any time, including mid-line) forces every register to its reset value immediately:
  - `div`=`h`=`v`=0.
  - `pixel_x`=`pixel_y`=0.
  - colour=0, `video_on`=0, `frame_start`=0.
  - `hsync`=`vsync`=1.
- Upstream requirement: `imemory` read latency must be ≤ CLK_DIV-1 clks. Its latency is 1 clk; this is an integration rule and is not checked in RTL.

## Timing
- The address for pixel (x,y) is stable from the clk after the `tick` that loads it until the next `tick`.
- `rgb_in` is sampled at the closing `tick` of that period.
- Pipeline latency: all VGA outputs lag the address by exactly one pixel period (CLK_DIV clks). Colour, syncs and `video_on` therefore stay mutually aligned.
- First `tick` after reset release with `en`=1: clk cycle CLK_DIV (div sequence 0,1,2,3).
- Line period = 800×CLK_DIV = 3200 clks.
- Frame period = 525 lines = 1,680,000 clks.
- `hsync` low width = 96 pixels = 384 clks.
- `vsync` low width = 2 lines = 6400 clks.
- Simultaneous `h` wrap and `v` wrap on the same `tick`: both counters are 0 afterwards, and `frame_start` pulses.

## Test plan
- Reset, then `en`=1, `rgb_in` echoes an `imemory` model (0xE12 for even x, 0x000 for odd x) -> `pixel_x` steps 0,1,2… every 4 clks; the first visible output at the DAC is 0xE12 with `video_on`=1, exactly 4 clks after address (0,0) was presented.
- Run one full line -> `hsync` falls exactly 657×4 clks after the line's first `tick`, stays low for 384 clks, and the line repeats every 3200 clks; colour is 0 for all `h`≥640.
- Run one full frame -> `vsync` low for 6400 clks starting at line 490; `frame_start` pulses once, exactly 1,680,000 clks after the previous pulse; `pixel_y` never exceeds 479.
- Constant `rgb_in`=0xFFF during blanking -> `vga_r`/`vga_g`/`vga_b` remain 0 whenever `video_on`=0.
- Assert `rst`=0 at pixel (300,200) mid-period -> all outputs take reset values in the same clk without waiting for `clk`; after release, timing restarts from (0,0).
- Drop `en` mid-frame for 10 clks, then raise it -> counters hold at 0, `hsync`/`vsync` stay 1, and `frame_start` pulses on restart.

Source files
------------

// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 VGA timing generator. Issues the imemory read address
// and registers colour/syncs one pixel period behind it so all pins stay aligned.
module vga_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    input  logic [11:0] rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          run;
    logic [11:0]   colour;
    logic          tick;
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          in_hs;
    logic          in_vs;

    always_comb begin
        tick    = (div == DIV_LAST);
        h_last  = (h == H_LAST);
        v_last  = (v == V_LAST);
        visible = (h < H_VIS_C) && (v < V_VIS_C);
        in_hs   = (h >= HS_BEG) && (h <= HS_END);
        in_vs   = (v >= VS_BEG) && (v <= VS_END);
    end

    // Address comes straight off the counter flops; only the visible mux follows.
    assign pixel_x = visible ? h : '0;
    assign pixel_y = visible ? v : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (!en) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    // Output stage samples pre-increment counters, so pins lag the address by one pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            colour      <= '0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (!en) begin
            run         <= 1'b0;
            colour      <= '0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            frame_start <= ~run | (tick & h_last & v_last);
            if (tick) begin
                video_on <= visible;
                colour   <= visible ? rgb_in : '0;
                hsync    <= ~in_hs;
                vsync    <= ~in_vs;
            end
        end
    end

    assign vga_r = colour[11:8];
    assign vga_g = colour[7:4];
    assign vga_b = colour[3:0];

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a full-size instance for line timing and a shrunken
// instance (16x10 pixel frame) scoreboarded cycle by cycle over whole frames.
module tb_vga_ctrl;

    localparam int SL     = 16;           // small line length
    localparam int SF     = 10;           // small frame length in lines
    localparam int SHV    = 8;
    localparam int SVV    = 4;
    localparam int SHS_B  = 10;
    localparam int SHS_E  = 12;
    localparam int SVS_B  = 6;
    localparam int SVS_E  = 7;
    localparam int SFRAME = SL * SF * 4;  // 640 clks

    localparam logic [35:0] RST_VAL = {1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 20'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic en = 1'b0;
    logic mode_fff = 1'b0;

    logic [9:0]  b_px, b_py, s_px, s_py;
    logic [11:0] b_rgb_in, s_rgb_in;
    logic [3:0]  b_r, b_g, b_b, s_r, s_g, s_b;
    logic        b_hs, b_vs, b_von, b_fs, s_hs, s_vs, s_von, s_fs;
    logic [11:0] b_rgb, s_rgb;
    logic [35:0] b_all, s_all;

    assign b_rgb = {b_r, b_g, b_b};
    assign s_rgb = {s_r, s_g, s_b};
    assign b_all = {b_von, b_hs, b_vs, b_rgb, b_fs, b_px, b_py};
    assign s_all = {s_von, s_hs, s_vs, s_rgb, s_fs, s_px, s_py};

    vga_ctrl #(.CLK_DIV(4)) u_big (
        .clk(clk), .rst(rst), .en(en),
        .pixel_x(b_px), .pixel_y(b_py), .rgb_in(b_rgb_in),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
    );

    vga_ctrl #(
        .CLK_DIV(4), .H_VIS(SHV), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(SVV), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst(rst), .en(en),
        .pixel_x(s_px), .pixel_y(s_py), .rgb_in(s_rgb_in),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
    );

    // imemory models: 1-clk read latency
    always @(posedge clk) begin
        b_rgb_in <= mode_fff ? 12'hFFF : (b_px[0] ? 12'h000 : 12'hE12);
        s_rgb_in <= mode_fff ? 12'hFFF : (s_px[0] ? 12'h000 : 12'hE12);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;                // enabled clk edges since the timing origin
    logic [14:0] sb[$];
    logic [14:0] cur;

    function automatic logic [14:0] exp_out(input int p, input logic fff);
        int h, v;
        logic vis;
        logic [11:0] c;
        h = p % SL;
        v = (p / SL) % SF;
        vis = (h < SHV) && (v < SVV);
        c = !vis ? 12'h000 : (fff ? 12'hFFF : ((h % 2 == 0) ? 12'hE12 : 12'h000));
        return {vis, !(h >= SHS_B && h <= SHS_E), !(v >= SVS_B && v <= SVS_E), c};
    endfunction

    // Reference timeline: push the expected pins for a pixel when its address is loaded.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 0;
            sb.delete();
        end else if (!en) begin
            cnt <= 0;
            sb.delete();
        end else begin
            cnt <= cnt + 1;
            if ((cnt + 1) % 4 == 1) sb.push_back(exp_out(cnt / 4, mode_fff));
        end
    end

    int m_h, m_v;
    logic m_vis, m_fs;
    logic [9:0] ex, ey;

    always @(negedge clk) begin
        m_h   = (cnt / 4) % SL;
        m_v   = (cnt / 4 / SL) % SF;
        m_vis = (m_h < SHV) && (m_v < SVV);
        ex    = m_vis ? 10'(m_h) : 10'd0;
        ey    = m_vis ? 10'(m_v) : 10'd0;
        n_cmp++;
        if (s_px !== ex || s_py !== ey) begin
            n_bad++;
            $display("FAIL sb_addr cnt=%0d got (%0d,%0d) want (%0d,%0d)", cnt, s_px, s_py, ex, ey);
        end
        m_fs = (cnt == 1) || (cnt != 0 && cnt % SFRAME == 0);
        n_cmp++;
        if (s_fs !== m_fs) begin
            n_bad++;
            $display("FAIL sb_frame_start cnt=%0d got %b want %b", cnt, s_fs, m_fs);
        end
        if (cnt < 4) begin
            cur = {1'b0, 1'b1, 1'b1, 12'h000};
        end else if (cnt % 4 == 0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow cnt=%0d got empty want entry", cnt);
            end else begin
                cur = sb.pop_front();
            end
        end
        n_cmp++;
        if ({s_von, s_hs, s_vs, s_rgb} !== cur) begin
            n_bad++;
            $display("FAIL sb_out cnt=%0d got von=%b hs=%b vs=%b rgb=%h want von=%b hs=%b vs=%b rgb=%h",
                     cnt, s_von, s_hs, s_vs, s_rgb, cur[14], cur[13], cur[12], cur[11:0]);
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b_all !== RST_VAL) begin
            n_bad++;
            $display("FAIL reset_big got %h want %h", b_all, RST_VAL);
        end
        n_cmp++;
        if (s_all !== RST_VAL) begin
            n_bad++;
            $display("FAIL reset_small got %h want %h", s_all, RST_VAL);
        end
    endtask

    task automatic test_pipeline();
        @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            case (cnt)
                3: begin
                    n_cmp++;
                    if (b_von !== 1'b0 || b_px !== 10'd0) begin
                        n_bad++;
                        $display("FAIL pipe_c3 got von=%b px=%0d want von=0 px=0", b_von, b_px);
                    end
                end
                4, 12: begin
                    n_cmp++;
                    if (b_von !== 1'b1 || b_rgb !== 12'hE12 || b_px !== 10'(cnt / 4)) begin
                        n_bad++;
                        $display("FAIL pipe_even cnt=%0d got von=%b rgb=%h px=%0d want von=1 rgb=e12 px=%0d",
                                 cnt, b_von, b_rgb, b_px, cnt / 4);
                    end
                end
                8: begin
                    n_cmp++;
                    if (b_von !== 1'b1 || b_rgb !== 12'h000 || b_px !== 10'd2) begin
                        n_bad++;
                        $display("FAIL pipe_odd got von=%b rgb=%h px=%0d want von=1 rgb=000 px=2", b_von, b_rgb, b_px);
                    end
                end
                default: ;
            endcase
        end
        repeat (1300) @(negedge clk);
    endtask

    task automatic test_line();
        int fall1, fall2, rise1, blank_err;
        logic prev_hs;
        fall1 = -1; fall2 = -1; rise1 = -1; blank_err = 0; prev_hs = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            if (prev_hs && !b_hs) begin
                if (fall1 < 0) fall1 = cnt;
                else if (fall2 < 0) fall2 = cnt;
            end
            if (!prev_hs && b_hs && rise1 < 0) rise1 = cnt;
            prev_hs = b_hs;
            if (!b_von && b_rgb != 12'h000) blank_err++;
            if (cnt >= 640 * 4 + 4 && cnt < 3200 && b_von) blank_err++;
        end
        n_cmp++;
        if (fall1 !== 657 * 4) begin
            n_bad++;
            $display("FAIL line_hs_fall got %0d want %0d", fall1, 657 * 4);
        end
        n_cmp++;
        if (rise1 - fall1 !== 384) begin
            n_bad++;
            $display("FAIL line_hs_width got %0d want 384", rise1 - fall1);
        end
        n_cmp++;
        if (fall2 - fall1 !== 3200) begin
            n_bad++;
            $display("FAIL line_period got %0d want 3200", fall2 - fall1);
        end
        n_cmp++;
        if (blank_err !== 0) begin
            n_bad++;
            $display("FAIL line_blank got %0d errors want 0", blank_err);
        end
    endtask

    task automatic test_frame();
        int fs_t[3];
        int n_fs, vs_fall, vs_rise, max_py;
        logic prev_vs;
        n_fs = 0; vs_fall = -1; vs_rise = -1; max_py = 0; prev_vs = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (s_fs) begin
                if (n_fs < 3) fs_t[n_fs] = cnt;
                n_fs++;
            end
            if (prev_vs && !s_vs && vs_fall < 0) vs_fall = cnt;
            if (!prev_vs && s_vs && vs_rise < 0) vs_rise = cnt;
            prev_vs = s_vs;
            if (int'(s_py) > max_py) max_py = int'(s_py);
        end
        n_cmp++;
        if (n_fs !== 3) begin
            n_bad++;
            $display("FAIL frame_pulses got %0d want 3", n_fs);
        end else begin
            n_cmp++;
            if (fs_t[0] !== 1 || fs_t[1] !== SFRAME || fs_t[2] - fs_t[1] !== SFRAME) begin
                n_bad++;
                $display("FAIL frame_times got %0d,%0d,%0d want 1,%0d,%0d", fs_t[0], fs_t[1], fs_t[2], SFRAME, 2 * SFRAME);
            end
        end
        n_cmp++;
        if (vs_fall !== (SVS_B * SL + 1) * 4) begin
            n_bad++;
            $display("FAIL frame_vs_fall got %0d want %0d", vs_fall, (SVS_B * SL + 1) * 4);
        end
        n_cmp++;
        if (vs_rise - vs_fall !== 2 * SL * 4) begin
            n_bad++;
            $display("FAIL frame_vs_width got %0d want %0d", vs_rise - vs_fall, 2 * SL * 4);
        end
        n_cmp++;
        if (max_py !== SVV - 1) begin
            n_bad++;
            $display("FAIL frame_max_py got %0d want %0d", max_py, SVV - 1);
        end
    endtask

    task automatic test_blanking();
        int err, von_cnt;
        err = 0; von_cnt = 0;
        @(posedge clk); #2 rst = 1'b0;
        mode_fff = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < SFRAME; i++) begin
            @(negedge clk);
            if (!s_von && s_rgb != 12'h000) err++;
            if (!b_von && b_rgb != 12'h000) err++;
            if (s_von && s_rgb !== 12'hFFF) err++;
            if (s_von) von_cnt++;
        end
        n_cmp++;
        if (err !== 0) begin
            n_bad++;
            $display("FAIL blank_colour got %0d errors want 0", err);
        end
        n_cmp++;
        if (von_cnt !== SHV * SVV * 4) begin
            n_bad++;
            $display("FAIL blank_von_cycles got %0d want %0d", von_cnt, SHV * SVV * 4);
        end
        @(posedge clk); #2 rst = 1'b0;
        mode_fff = 1'b0;
    endtask

    task automatic test_async_reset();
        logic found;
        found = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (cnt == (2 * SL + 5) * 4 + 2) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL arst_reach got timeout want cnt=%0d", (2 * SL + 5) * 4 + 2);
        end else begin
            n_cmp++;
            if (s_px !== 10'd5 || s_py !== 10'd2 || s_von !== 1'b1) begin
                n_bad++;
                $display("FAIL arst_pre got (%0d,%0d) von=%b want (5,2) von=1", s_px, s_py, s_von);
            end
            #1 rst = 1'b0;
            #1;
            n_cmp++;
            if (s_all !== RST_VAL) begin
                n_bad++;
                $display("FAIL arst_small got %h want %h", s_all, RST_VAL);
            end
            n_cmp++;
            if (b_all !== RST_VAL) begin
                n_bad++;
                $display("FAIL arst_big got %h want %h", b_all, RST_VAL);
            end
        end
        @(posedge clk); #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cnt !== 4 || s_px !== 10'd1 || s_von !== 1'b1 || s_rgb !== 12'hE12) begin
            n_bad++;
            $display("FAIL arst_restart got cnt=%0d px=%0d von=%b rgb=%h want cnt=4 px=1 von=1 rgb=e12",
                     cnt, s_px, s_von, s_rgb);
        end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_en_drop();
        logic found;
        found = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (cnt == (SVS_B * SL + SHS_B + 1) * 4 + 1) found = 1'b1;
        end
        n_cmp++;
        if (!found || s_hs !== 1'b0 || s_vs !== 1'b0) begin
            n_bad++;
            $display("FAIL en_pre found=%b got hs=%b vs=%b want hs=0 vs=0", found, s_hs, s_vs);
        end
        @(posedge clk); #2 en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (s_px !== 10'd0 || s_py !== 10'd0 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_fs !== 1'b0) begin
                n_bad++;
                $display("FAIL en_low i=%0d got px=%0d py=%0d hs=%b vs=%b fs=%b want 0 0 1 1 0",
                         i, s_px, s_py, s_hs, s_vs, s_fs);
            end
        end
        @(posedge clk); #2 en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (s_fs !== 1'b1 || b_fs !== 1'b1) begin
            n_bad++;
            $display("FAIL en_restart_fs got small=%b big=%b want 1 1", s_fs, b_fs);
        end
        @(negedge clk);
        n_cmp++;
        if (s_fs !== 1'b0 || b_fs !== 1'b0) begin
            n_bad++;
            $display("FAIL en_fs_width got small=%b big=%b want 0 0", s_fs, b_fs);
        end
        repeat (SFRAME + 40) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pipeline();
        test_line();
        test_frame();
        test_blanking();
        test_async_reset();
        test_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
